ace_read_arbiter: RTL and testbench

Two-master arbiter for the core's single ACE read port. It shares one AR/R channel pair between the instruction-fetch cache (master 0) and the data cache (master 1), with one transaction in flight at a time. It sits between the two L1 controllers and the system interconnect. It owns round-robin grant, AR registration, R-beat routing and RACK generation.

---
 rtl/ace_read_arbiter.sv | 240 ++++++++++++++++++++++++
 tb/tb_ace_read_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ace_read_arbiter.sv
// ============================================================================
// ace_read_arbiter
// ----------------------------------------------------------------------------
// Shares the core's single ACE read port (one AR channel, one R channel)
// between the instruction-fetch cache (master 0) and the data cache
// (master 1). Only one read transaction is in flight at any time.
//
// Responsibilities:
//   - round-robin grant between the two masters when both request
//   - registering the granted AR request toward the interconnect
//   - routing R beats back to the granted master only
//   - generating the one-cycle RACK pulse after the last R handshake
//
// Port summary:
//   clk, rst                  clock, synchronous active-high reset
//   m{0,1}_ar*                per-master AR request (valid/ready + fields)
//   m{0,1}_r*                 per-master R response (valid/ready + beat)
//   s_ar*                     registered AR request toward the interconnect
//   s_arid                    index of the granted master
//   s_r*                      R response from the interconnect
//   s_rack                    ACE read acknowledge
//
// Transaction flow: IDLE (grant + capture) -> ADDR (AR handshake)
//                   -> DATA (beats) -> ACK (RACK) -> IDLE
// ============================================================================
module ace_read_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // ---------------- master 0 (instruction fetch) AR ----------------
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    input  logic [ADDR_WIDTH-1:0] m0_araddr,
    input  logic [7:0]            m0_arlen,
    input  logic [2:0]            m0_arsize,
    input  logic [1:0]            m0_arburst,
    input  logic [3:0]            m0_arcache,
    input  logic [2:0]            m0_arprot,
    input  logic [3:0]            m0_arsnoop,
    input  logic [1:0]            m0_ardomain,
    input  logic [1:0]            m0_arbar,

    // ---------------- master 0 R ----------------
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [3:0]            m0_rresp,
    output logic                  m0_rlast,

    // ---------------- master 1 (data cache) AR ----------------
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    input  logic [ADDR_WIDTH-1:0] m1_araddr,
    input  logic [7:0]            m1_arlen,
    input  logic [2:0]            m1_arsize,
    input  logic [1:0]            m1_arburst,
    input  logic [3:0]            m1_arcache,
    input  logic [2:0]            m1_arprot,
    input  logic [3:0]            m1_arsnoop,
    input  logic [1:0]            m1_ardomain,
    input  logic [1:0]            m1_arbar,

    // ---------------- master 1 R ----------------
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [3:0]            m1_rresp,
    output logic                  m1_rlast,

    // ---------------- interconnect AR ----------------
    output logic                  s_arvalid,
    input  logic                  s_arready,
    output logic                  s_arid,
    output logic [ADDR_WIDTH-1:0] s_araddr,
    output logic [7:0]            s_arlen,
    output logic [2:0]            s_arsize,
    output logic [1:0]            s_arburst,
    output logic [3:0]            s_arcache,
    output logic [2:0]            s_arprot,
    output logic [3:0]            s_arsnoop,
    output logic [1:0]            s_ardomain,
    output logic [1:0]            s_arbar,

    // ---------------- interconnect R ----------------
    input  logic                  s_rvalid,
    output logic                  s_rready,
    input  logic                  s_rid,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [3:0]            s_rresp,
    input  logic                  s_rlast,
    output logic                  s_rack
);

    // ------------------------------------------------------------------
    // FSM encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    logic [1:0] state;
    logic [1:0] state_next;

    // Master that won the most recent completed transaction. Resets to 1
    // so that master 0 wins the first tie after reset.
    logic       last_grant;

    // Arbitration
    logic       req_any;
    logic       pick;        // master selected this cycle (valid when take=1)
    logic       take;        // a grant happens this cycle

    // R routing
    logic       in_data;
    logic       route_m0;
    logic       route_m1;
    logic       granted_rready;
    logic       r_done;      // final R handshake of the burst

    // Only one transaction is ever outstanding, so R routing uses the
    // registered grant (s_arid) instead of the returned ID.
    logic       rid_unused;
    assign rid_unused = s_rid;

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins outright; on a tie the master
    // that was not granted last wins.
    // ------------------------------------------------------------------
    assign req_any = m0_arvalid | m1_arvalid;
    assign pick    = (m0_arvalid && m1_arvalid) ? ~last_grant : m1_arvalid;

    // Grant is suppressed while reset is asserted so that no master sees
    // its request accepted by a transaction that is about to be discarded.
    assign take    = (state == ST_IDLE) && req_any && !rst;

    assign m0_arready = take && !pick;
    assign m1_arready = take &&  pick;

    // ------------------------------------------------------------------
    // Interconnect-facing strobes decoded straight from the state
    // register, so they are glitch-free and drop to 0 once the state
    // register returns to IDLE.
    // ------------------------------------------------------------------
    assign s_arvalid = (state == ST_ADDR);
    assign s_rack    = (state == ST_ACK);

    // ------------------------------------------------------------------
    // R routing: zero-latency pass-through to the granted master only.
    // The other master sees all R outputs held at 0.
    // ------------------------------------------------------------------
    assign in_data  = (state == ST_DATA);
    assign route_m0 = in_data && !s_arid;
    assign route_m1 = in_data &&  s_arid;

    assign granted_rready = s_arid ? m1_rready : m0_rready;
    assign s_rready       = in_data && granted_rready;

    assign m0_rvalid = route_m0 && s_rvalid;
    assign m0_rdata  = route_m0 ? s_rdata : '0;
    assign m0_rresp  = route_m0 ? s_rresp : '0;
    assign m0_rlast  = route_m0 && s_rlast;

    assign m1_rvalid = route_m1 && s_rvalid;
    assign m1_rdata  = route_m1 ? s_rdata : '0;
    assign m1_rresp  = route_m1 ? s_rresp : '0;
    assign m1_rlast  = route_m1 && s_rlast;

    // Error responses in rresp are passed through and do not influence
    // sequencing; the burst ends purely on the last handshake.
    assign r_done = s_rvalid && s_rready && s_rlast;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: default assignment first so every path drives state_next
        // and no latch is inferred.
        state_next = state;
        case (state)
            ST_IDLE: if (take)      state_next = ST_ADDR;
            ST_ADDR: if (s_arready) state_next = ST_DATA;
            ST_DATA: if (r_done)    state_next = ST_ACK;
            ST_ACK:                 state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequential state: FSM, round-robin history and the registered AR
    // request. The captured request is held unchanged through ADDR so the
    // interconnect sees stable fields until it accepts them.
    // ------------------------------------------------------------------
    // NOTE: non-blocking assignments for all registered state so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        // NOTE: every register here, including the AR field copies, is
        // reset so the outputs are defined 0 straight out of reset.
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            s_arid     <= 1'b0;
            s_araddr   <= '0;
            s_arlen    <= '0;
            s_arsize   <= '0;
            s_arburst  <= '0;
            s_arcache  <= '0;
            s_arprot   <= '0;
            s_arsnoop  <= '0;
            s_ardomain <= '0;
            s_arbar    <= '0;
        end else begin
            state <= state_next;

            if (take) begin
                s_arid     <= pick;
                s_araddr   <= pick ? m1_araddr   : m0_araddr;
                s_arlen    <= pick ? m1_arlen    : m0_arlen;
                s_arsize   <= pick ? m1_arsize   : m0_arsize;
                s_arburst  <= pick ? m1_arburst  : m0_arburst;
                s_arcache  <= pick ? m1_arcache  : m0_arcache;
                s_arprot   <= pick ? m1_arprot   : m0_arprot;
                s_arsnoop  <= pick ? m1_arsnoop  : m0_arsnoop;
                s_ardomain <= pick ? m1_ardomain : m0_ardomain;
                s_arbar    <= pick ? m1_arbar    : m0_arbar;
            end

            // Round-robin history advances only once a transaction has
            // fully completed, so an abandoned (reset) transaction does
            // not count as a win.
            if (state == ST_ACK) begin
                last_grant <= s_arid;
            end
        end
    end

endmodule

// File: tb/tb_ace_read_arbiter.sv
// ============================================================================
// tb_ace_read_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for ace_read_arbiter. A behavioural model tracks the
// round-robin history and the expected beat stream; each scenario task
// drives stimulus and compares DUT outputs inline.
// ============================================================================
module tb_ace_read_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int DATA_CYCLE_LIMIT = 300;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    len;
        logic [2:0]    size;
        logic [1:0]    burst;
        logic [3:0]    cache;
        logic [2:0]    prot;
        logic [3:0]    snoop;
        logic [1:0]    domain;
        logic [1:0]    bar;
    } ar_desc_t;

    logic clk = 1'b0;
    logic rst;

    logic m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    ar_desc_t desc0, desc1;
    logic [AW-1:0] m0_araddr, m1_araddr;
    logic [7:0] m0_arlen, m1_arlen;
    logic [2:0] m0_arsize, m1_arsize, m0_arprot, m1_arprot;
    logic [1:0] m0_arburst, m1_arburst, m0_ardomain, m1_ardomain, m0_arbar, m1_arbar;
    logic [3:0] m0_arcache, m1_arcache, m0_arsnoop, m1_arsnoop;

    logic m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [3:0] m0_rresp, m1_rresp;

    logic s_arvalid, s_arready, s_arid;
    logic [AW-1:0] s_araddr;
    logic [7:0] s_arlen;
    logic [2:0] s_arsize, s_arprot;
    logic [1:0] s_arburst, s_ardomain, s_arbar;
    logic [3:0] s_arcache, s_arsnoop;
    logic s_rvalid, s_rready, s_rid, s_rlast, s_rack;
    logic [DW-1:0] s_rdata;
    logic [3:0] s_rresp;

    ar_desc_t s_desc;
    logic [2*DW+2*4+2+2+1+1+$bits(ar_desc_t)+1+1+1-1:0] all_out;

    assign {m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arcache,
            m0_arprot, m0_arsnoop, m0_ardomain, m0_arbar} = desc0;
    assign {m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arcache,
            m1_arprot, m1_arsnoop, m1_ardomain, m1_arbar} = desc1;
    assign s_desc = {s_araddr, s_arlen, s_arsize, s_arburst, s_arcache,
                     s_arprot, s_arsnoop, s_ardomain, s_arbar};
    assign all_out = {m0_rdata, m1_rdata, m0_rresp, m1_rresp,
                      m0_arready, m1_arready, m0_rvalid, m1_rvalid,
                      m0_rlast, m1_rlast, s_arvalid, s_arid, s_desc,
                      s_rready, s_rack};

    ace_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_arlen(m0_arlen), .m0_arsize(m0_arsize), .m0_arburst(m0_arburst),
        .m0_arcache(m0_arcache), .m0_arprot(m0_arprot), .m0_arsnoop(m0_arsnoop),
        .m0_ardomain(m0_ardomain), .m0_arbar(m0_arbar),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata),
        .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_arlen(m1_arlen), .m1_arsize(m1_arsize), .m1_arburst(m1_arburst),
        .m1_arcache(m1_arcache), .m1_arprot(m1_arprot), .m1_arsnoop(m1_arsnoop),
        .m1_ardomain(m1_ardomain), .m1_arbar(m1_arbar),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata),
        .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arcache(s_arcache), .s_arprot(s_arprot),
        .s_arsnoop(s_arsnoop), .s_ardomain(s_ardomain), .s_arbar(s_arbar),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rack(s_rack)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model state and bookkeeping
    // ------------------------------------------------------------------
    logic          exp_last;          // master that won the last completed read
    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] sent_q[$];         // beats offered by the interconnect, in order
    logic [DW-1:0] got_q[$];          // beats observed at the granted master on handshake
    logic [DW-1:0] rd_q[$];           // optional preset beat data
    logic [3:0]    rs_q[$];           // optional preset beat responses

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ar_desc_t rand_desc();
        ar_desc_t d;
        d.addr   = $urandom;
        d.len    = 8'($urandom_range(0, 7));
        d.size   = 3'($urandom);
        d.burst  = 2'($urandom);
        d.cache  = 4'($urandom);
        d.prot   = 3'($urandom);
        d.snoop  = 4'($urandom);
        d.domain = 2'($urandom);
        d.bar    = 2'($urandom);
        return d;
    endfunction

    // ------------------------------------------------------------------
    // One complete read transaction, checked cycle by cycle.
    //   r0/r1    arvalid of each master in the IDLE cycle
    //   hold     granted master keeps arvalid high after the grant
    //   stall    cycles s_arready stays low in ADDR
    //   rr_mode  0: granted rready always 1, 1: toggles 1,0,1,0, 2: random
    //   rv_rand  interconnect inserts random rvalid gaps
    // ------------------------------------------------------------------
    task automatic run_txn(input logic r0, input logic r1, input bit hold,
                           input int stall, input int rr_mode, input bit rv_rand,
                           output int g_out);
        int g, beats, beat, cyc;
        bit hs;
        ar_desc_t cap;
        logic [DW-1:0] data;
        logic [3:0] resp;
        logic rv, rr, lst;
        logic o_rv, o_rl, x_rv, x_rl;
        logic [DW-1:0] o_rd, x_rd;
        logic [3:0] o_rs, x_rs;

        // ---- IDLE: combinational grant ----
        m0_arvalid = r0;
        m1_arvalid = r1;
        s_arready  = 1'b0;
        s_rvalid   = 1'b0;
        s_rlast    = 1'b0;
        #1;
        if (r0 && r1) g = exp_last ? 0 : 1;
        else          g = r1 ? 1 : 0;
        cap = (g == 0) ? desc0 : desc1;
        n_checks++;
        if ({m0_arready, m1_arready, s_arvalid, s_rack} !== {g == 0, g == 1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL grant: {m0_arready,m1_arready,s_arvalid,s_rack}=%b expected %b",
                     {m0_arready, m1_arready, s_arvalid, s_rack}, {g == 0, g == 1, 2'b00});
        end
        step();

        // Granted master releases (unless holding) and changes its fields,
        // which must not disturb the registered copy.
        if (!hold) begin
            if (g == 0) m0_arvalid = 1'b0; else m1_arvalid = 1'b0;
        end
        if (g == 0) desc0 = rand_desc(); else desc1 = rand_desc();

        // ---- ADDR ----
        for (int i = 0; i <= stall; i++) begin
            s_arready = (i == stall);
            #1;
            n_checks++;
            if ({s_arvalid, s_arid, m0_arready, m1_arready} !== {1'b1, 1'(g), 2'b00}) begin
                n_fail++;
                $display("FAIL addr_phase cyc%0d: {s_arvalid,s_arid,m0_arready,m1_arready}=%b expected %b",
                         i, {s_arvalid, s_arid, m0_arready, m1_arready}, {1'b1, 1'(g), 2'b00});
            end
            n_checks++;
            if (s_desc !== cap) begin
                n_fail++;
                $display("FAIL ar_fields cyc%0d: got %h expected %h", i, s_desc, cap);
            end
            step();
        end
        s_arready = 1'b0;

        // ---- DATA ----
        beats = int'(cap.len) + 1;
        sent_q.delete();
        got_q.delete();
        cyc = 0;
        beat = 0;
        s_rid = 1'(g);
        while (beat < beats && cyc < DATA_CYCLE_LIMIT) begin
            data = (rd_q.size() > 0) ? rd_q.pop_front() : DW'($urandom);
            resp = (rs_q.size() > 0) ? rs_q.pop_front() : 4'($urandom);
            lst  = (beat == beats - 1);
            sent_q.push_back(data);
            hs = 1'b0;
            while (!hs && cyc < DATA_CYCLE_LIMIT) begin
                rv = rv_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                case (rr_mode)
                    0:       rr = 1'b1;
                    1:       rr = (cyc % 2 == 0);
                    default: rr = 1'($urandom_range(0, 1));
                endcase
                s_rvalid = rv;
                s_rdata  = data;
                s_rresp  = resp;
                s_rlast  = lst;
                if (g == 0) begin
                    m0_rready = rr;
                    m1_rready = 1'($urandom);
                end else begin
                    m1_rready = rr;
                    m0_rready = 1'($urandom);
                end
                #1;
                if (g == 0) begin
                    {o_rv, o_rd, o_rs, o_rl} = {m0_rvalid, m0_rdata, m0_rresp, m0_rlast};
                    {x_rv, x_rd, x_rs, x_rl} = {m1_rvalid, m1_rdata, m1_rresp, m1_rlast};
                end else begin
                    {o_rv, o_rd, o_rs, o_rl} = {m1_rvalid, m1_rdata, m1_rresp, m1_rlast};
                    {x_rv, x_rd, x_rs, x_rl} = {m0_rvalid, m0_rdata, m0_rresp, m0_rlast};
                end
                n_checks++;
                if ({o_rv, o_rd, o_rs, o_rl} !== {rv, data, resp, lst}) begin
                    n_fail++;
                    $display("FAIL r_route m%0d beat%0d: rvalid=%b rdata=%h rresp=%b rlast=%b expected %b %h %b %b",
                             g, beat, o_rv, o_rd, o_rs, o_rl, rv, data, resp, lst);
                end
                n_checks++;
                if ({x_rv, x_rd, x_rs, x_rl} !== '0) begin
                    n_fail++;
                    $display("FAIL r_isolate m%0d: rvalid=%b rdata=%h rresp=%b rlast=%b expected all 0",
                             1 - g, x_rv, x_rd, x_rs, x_rl);
                end
                n_checks++;
                if ({s_rready, s_rack, s_arvalid, m0_arready, m1_arready} !== {rr, 4'b0000}) begin
                    n_fail++;
                    $display("FAIL data_ctrl: {s_rready,s_rack,s_arvalid,m0_arready,m1_arready}=%b expected %b",
                             {s_rready, s_rack, s_arvalid, m0_arready, m1_arready}, {rr, 4'b0000});
                end
                hs = rv && rr;
                if (hs) got_q.push_back(o_rd);
                step();
                cyc++;
            end
            beat++;
        end
        if (cyc >= DATA_CYCLE_LIMIT) begin
            n_checks++;
            n_fail++;
            $display("FAIL data_timeout: %0d of %0d beats after %0d cycles", beat, beats, cyc);
        end

        // ---- ACK ----
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        #1;
        n_checks++;
        if ({s_rack, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready, s_arvalid} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL ack: {s_rack,s_rready,m0_rvalid,m1_rvalid,m0_arready,m1_arready,s_arvalid}=%b expected 1000000",
                     {s_rack, s_rready, m0_rvalid, m1_rvalid, m0_arready, m1_arready, s_arvalid});
        end
        exp_last = 1'(g);
        step();

        n_checks++;
        if (got_q.size() != sent_q.size()) begin
            n_fail++;
            $display("FAIL beat_count: got %0d beats expected %0d", got_q.size(), sent_q.size());
        end else begin
            for (int i = 0; i < sent_q.size(); i++) begin
                n_checks++;
                if (got_q[i] !== sent_q[i]) begin
                    n_fail++;
                    $display("FAIL beat_order[%0d]: got %h expected %h", i, got_q[i], sent_q[i]);
                end
            end
        end
        g_out = g;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        m0_arvalid = 1'b0; m1_arvalid = 1'b0;
        m0_rready = 1'b1;  m1_rready = 1'b1;
        s_arready = 1'b1;  s_rvalid = 1'b1;
        s_rid = 1'b0; s_rdata = 32'hA5A5_5A5A; s_rresp = 4'hF; s_rlast = 1'b1;
        desc0 = rand_desc(); desc1 = rand_desc();
        step(); step();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        rst = 1'b0;
        s_rvalid = 1'b0; s_rlast = 1'b0; s_arready = 1'b0;
        step();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got %h expected 0", all_out);
        end
        exp_last = 1'b1;
    endtask

    task automatic test_single_read();
        int g;
        ar_desc_t d;
        d = rand_desc();
        d.addr = 32'h0000_1000;
        d.len  = 8'd0;
        desc0 = d;
        rd_q.push_back(32'hDEAD_BEEF);
        rs_q.push_back(4'b0000);
        run_txn(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, g);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL single_read_data: got %0d beats first %h expected 1 beat deadbeef",
                     got_q.size(), (got_q.size() > 0) ? got_q[0] : 32'h0);
        end
    endtask

    task automatic test_contention();
        int g;
        for (int i = 0; i < 4; i++) run_txn(1'b1, 1'b1, 1'b1, 0, 0, 1'b0, g);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
    endtask

    task automatic test_burst_backpressure();
        int g;
        ar_desc_t d;
        d = rand_desc();
        d.len = 8'd3;
        desc1 = d;
        run_txn(1'b0, 1'b1, 1'b0, 0, 1, 1'b0, g);
    endtask

    task automatic test_ar_stall();
        int g;
        run_txn(1'b1, 1'b1, 1'b0, 5, 0, 1'b0, g);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
    endtask

    task automatic test_error_passthrough();
        int g;
        ar_desc_t d;
        d = rand_desc();
        d.len = 8'd1;
        desc0 = d;
        rs_q.push_back(4'b0000);
        rs_q.push_back(4'b0010);
        run_txn(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, g);
        // Back in IDLE: an immediate follow-up request must be granted.
        run_txn(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, g);
    endtask

    task automatic test_reset_mid_burst();
        int g;
        ar_desc_t d;
        // Leave master 0 as the last winner so the post-reset tie is telling.
        run_txn(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, g);
        d = rand_desc();
        d.len = 8'd3;
        desc1 = d;
        m1_arvalid = 1'b1;
        #1;
        n_checks++;
        if ({m0_arready, m1_arready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rst_burst_grant: {m0_arready,m1_arready}=%b expected 01", {m0_arready, m1_arready});
        end
        step();
        m1_arvalid = 1'b0;
        s_arready  = 1'b1;
        step();
        s_arready = 1'b0;
        m1_rready = 1'b1;
        s_rlast   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_rvalid = 1'b1;
            s_rdata  = $urandom;
            #1;
            n_checks++;
            if ({m1_rvalid, m1_rdata} !== {1'b1, s_rdata}) begin
                n_fail++;
                $display("FAIL rst_burst_beat%0d: m1_rvalid=%b m1_rdata=%h expected 1 %h",
                         i, m1_rvalid, m1_rdata, s_rdata);
            end
            step();
        end
        // Beat 3 is on the bus when reset hits.
        s_rvalid = 1'b1;
        s_rdata  = $urandom;
        rst = 1'b1;
        step();
        n_checks++;
        if (all_out !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_burst_outputs: got %h expected 0", all_out);
        end
        rst = 1'b0;
        s_rvalid = 1'b0;
        exp_last = 1'b1;
        run_txn(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, g);
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
    endtask

    task automatic test_random();
        int g;
        logic r0, r1;
        for (int i = 0; i < 20; i++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            run_txn(r0, r1, 1'($urandom), int'($urandom_range(0, 3)), 2, 1'b1, g);
        end
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_burst_backpressure();
        test_ar_stall();
        test_error_passthrough();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
